// File: rtl/pattern_gen.sv
// Multi-mode video test-pattern generator with a 2-clock pixel pipeline.
// Define PATTERN_BOX_EN to compile in the bouncing-box registers and mode 4.
module pattern_gen #(
    parameter int unsigned H_ACTIVE  = 1920,
    parameter int unsigned V_ACTIVE  = 1080,
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned COLOR_W   = 8,
    parameter int unsigned BAR_SHIFT = 8,
    parameter int unsigned CHK_SHIFT = 5,
    parameter int unsigned BOX_SIZE  = 64,
    parameter int unsigned BOX_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   de,
    input  logic [ADDR_W-1:0]      h_addr,
    input  logic [ADDR_W-1:0]      v_addr,
    input  logic [2:0]             mode_i,
    output logic [3*COLOR_W-1:0]   data_disp,
    output logic                   de_o,
    output logic [2:0]             mode_o,
    output logic [15:0]            frame_cnt
);

    localparam int unsigned PIX_W = 3 * COLOR_W;

    localparam logic [2:0] MODE_BARS    = 3'd0;
    localparam logic [2:0] MODE_RAMP    = 3'd1;
    localparam logic [2:0] MODE_CHECKER = 3'd2;
    localparam logic [2:0] MODE_GRID    = 3'd3;
    localparam logic [2:0] MODE_BOX     = 3'd4;
    localparam logic [2:0] MODE_FLOOD   = 3'd5;

    localparam logic [COLOR_W-1:0] FULL = '1;
    localparam logic [COLOR_W-1:0] ZERO = '0;
    // 0xC0 aligned to the channel MSBs
    localparam logic [COLOR_W-1:0] GREY = COLOR_W'((COLOR_W >= 8) ?
        (32'hC0 << (COLOR_W - 8)) : (32'hC0 >> (8 - COLOR_W)));

    typedef logic [PIX_W-1:0] pixel_t;

    function automatic pixel_t bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return {FULL, ZERO, ZERO};
            3'd1:    return {ZERO, FULL, ZERO};
            3'd2:    return {ZERO, ZERO, FULL};
            3'd3:    return {FULL, FULL, ZERO};
            3'd4:    return {ZERO, FULL, FULL};
            3'd5:    return {FULL, ZERO, FULL};
            3'd6:    return {GREY, GREY, GREY};
            default: return {FULL, FULL, FULL};
        endcase
    endfunction

    logic               eof_c;
    logic [2:0]         idx_c;
    logic               white_c;
    logic               in_box_c;

    logic               s1_de;
    logic [2:0]         s1_mode;
    logic [2:0]         s1_idx;
    logic [COLOR_W-1:0] s1_gray;
    logic               s1_white;
    logic               s1_box;
    pixel_t             color_c;

    assign eof_c = de && (h_addr == ADDR_W'(H_ACTIVE - 1))
                      && (v_addr == ADDR_W'(V_ACTIVE - 1));

    // Frame-boundary state: mode in effect and completed-frame count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_o    <= '0;
            frame_cnt <= '0;
        end else if (eof_c) begin
            mode_o    <= mode_i;
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef PATTERN_BOX_EN
    localparam logic [ADDR_W:0] BOX_REACH = (ADDR_W + 1)'(BOX_SIZE + BOX_STEP);
    localparam logic [ADDR_W:0] BOX_EXT   = (ADDR_W + 1)'(BOX_SIZE);

    logic [ADDR_W-1:0] box_x, box_y, box_x_nxt, box_y_nxt;
    logic              dir_left, dir_up, dir_left_nxt, dir_up_nxt;

    // Bounce each axis off the active-area edges
    always_comb begin
        box_x_nxt    = box_x;
        box_y_nxt    = box_y;
        dir_left_nxt = dir_left;
        dir_up_nxt   = dir_up;
        if (!dir_left) begin
            if ({1'b0, box_x} + BOX_REACH > (ADDR_W + 1)'(H_ACTIVE)) begin
                box_x_nxt    = ADDR_W'(H_ACTIVE - BOX_SIZE);
                dir_left_nxt = 1'b1;
            end else begin
                box_x_nxt = box_x + ADDR_W'(BOX_STEP);
            end
        end else if (box_x < ADDR_W'(BOX_STEP)) begin
            box_x_nxt    = '0;
            dir_left_nxt = 1'b0;
        end else begin
            box_x_nxt = box_x - ADDR_W'(BOX_STEP);
        end
        if (!dir_up) begin
            if ({1'b0, box_y} + BOX_REACH > (ADDR_W + 1)'(V_ACTIVE)) begin
                box_y_nxt  = ADDR_W'(V_ACTIVE - BOX_SIZE);
                dir_up_nxt = 1'b1;
            end else begin
                box_y_nxt = box_y + ADDR_W'(BOX_STEP);
            end
        end else if (box_y < ADDR_W'(BOX_STEP)) begin
            box_y_nxt  = '0;
            dir_up_nxt = 1'b0;
        end else begin
            box_y_nxt = box_y - ADDR_W'(BOX_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            box_x    <= '0;
            box_y    <= '0;
            dir_left <= 1'b0;
            dir_up   <= 1'b0;
        end else if (eof_c) begin
            box_x    <= box_x_nxt;
            box_y    <= box_y_nxt;
            dir_left <= dir_left_nxt;
            dir_up   <= dir_up_nxt;
        end
    end

    assign in_box_c = (h_addr >= box_x) && ({1'b0, h_addr} < {1'b0, box_x} + BOX_EXT)
                   && (v_addr >= box_y) && ({1'b0, v_addr} < {1'b0, box_y} + BOX_EXT);
`else
    logic box_cfg_unused;
    assign box_cfg_unused = ^{BOX_SIZE, BOX_STEP};
    assign in_box_c       = 1'b0;
`endif

    // Stage-1 region decisions
    always_comb begin
        idx_c   = 3'(h_addr >> BAR_SHIFT);
        white_c = (h_addr[CHK_SHIFT-1:0] == '0) || (v_addr[CHK_SHIFT-1:0] == '0)
               || (h_addr == ADDR_W'(H_ACTIVE - 1)) || (v_addr == ADDR_W'(V_ACTIVE - 1));
        if (mode_o == MODE_FLOOD) begin
            idx_c = frame_cnt[8:6];
        end
        if (mode_o == MODE_CHECKER) begin
            white_c = h_addr[CHK_SHIFT] ^ v_addr[CHK_SHIFT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_de    <= 1'b0;
            s1_mode  <= '0;
            s1_idx   <= '0;
            s1_gray  <= '0;
            s1_white <= 1'b0;
            s1_box   <= 1'b0;
        end else begin
            s1_de    <= de;
            s1_mode  <= mode_o;
            s1_idx   <= idx_c;
            s1_gray  <= h_addr[COLOR_W-1:0];
            s1_white <= white_c;
            s1_box   <= in_box_c;
        end
    end

    // Stage-2 colour selection; blank outside the active area
    always_comb begin
        color_c = '0;
        if (s1_de) begin
            case (s1_mode)
                MODE_BARS, MODE_FLOOD:   color_c = bar_color(s1_idx);
                MODE_RAMP:               color_c = {s1_gray, s1_gray, s1_gray};
                MODE_CHECKER, MODE_GRID: color_c = {PIX_W{s1_white}};
`ifdef PATTERN_BOX_EN
                MODE_BOX:                color_c = s1_box ? {FULL, ZERO, ZERO} : {ZERO, ZERO, FULL};
`else
                MODE_BOX:                color_c = {PIX_W{s1_box}};
`endif
                default:                 color_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_disp <= '0;
            de_o      <= 1'b0;
        end else begin
            data_disp <= color_c;
            de_o      <= s1_de;
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Randomised bench for pattern_gen against a frame-level behavioural model.
// Honours PATTERN_BOX_EN the same way as the design.
module tb_pattern_gen;

    localparam int H = 1920;
    localparam int V = 1080;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        de;
    logic [11:0] h_addr;
    logic [11:0] v_addr;
    logic [2:0]  mode_i;
    logic [23:0] data_disp;
    logic        de_o;
    logic [2:0]  mode_o;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    pattern_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .de        (de),
        .h_addr    (h_addr),
        .v_addr    (v_addr),
        .mode_i    (mode_i),
        .data_disp (data_disp),
        .de_o      (de_o),
        .mode_o    (mode_o),
        .frame_cnt (frame_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Frame-level model state
    int m_mode, m_fc, m_bx, m_by;
    bit m_xl, m_yu;
    int pend_pix, exp_pix;
    bit pend_de, exp_de;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int bar(input int i);
        case (i & 7)
            0:       return 'hFF0000;
            1:       return 'h00FF00;
            2:       return 'h0000FF;
            3:       return 'hFFFF00;
            4:       return 'h00FFFF;
            5:       return 'hFF00FF;
            6:       return 'hC0C0C0;
            default: return 'hFFFFFF;
        endcase
    endfunction

    function automatic int ref_pixel(input int h, input int v);
        case (m_mode)
            0: return bar(h / 256);
            1: return (h % 256) * 'h010101;
            2: return (((h / 32) ^ (v / 32)) & 1) ? 'hFFFFFF : 0;
            3: return (h % 32 == 0 || v % 32 == 0 || h == H - 1 || v == V - 1) ? 'hFFFFFF : 0;
`ifdef PATTERN_BOX_EN
            4: return (h >= m_bx && h < m_bx + 64 && v >= m_by && v < m_by + 64) ? 'hFF0000 : 'h0000FF;
`endif
            5: return bar(m_fc / 64);
            default: return 0;
        endcase
    endfunction

    task automatic bounce(inout int pos, inout bit back, input int lim);
        if (!back) begin
            if (pos + 64 + 4 > lim) begin
                pos  = lim - 64;
                back = 1'b1;
            end else begin
                pos += 4;
            end
        end else if (pos < 4) begin
            pos  = 0;
            back = 1'b0;
        end else begin
            pos -= 4;
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_fc = 0; m_bx = 0; m_by = 0; m_xl = 1'b0; m_yu = 1'b0;
        pend_pix = 0; pend_de = 1'b0; exp_pix = 0; exp_de = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data_disp"}, 32'(data_disp), 32'(exp_pix));
        check({tag, ".de_o"},      32'(de_o),      32'(exp_de));
        check({tag, ".mode_o"},    32'(mode_o),    32'(m_mode));
        check({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(m_fc));
    endtask

    // Drive one pixel, advance one clock, update the model, compare outputs
    task automatic apply(input string tag, input bit d, input int h, input int v, input int m);
        int hm, vm;
        hm = h & 'hFFF;
        vm = v & 'hFFF;
        de = d; h_addr = 12'(hm); v_addr = 12'(vm); mode_i = 3'(m);
        @(posedge clk);
        exp_pix  = pend_pix;
        exp_de   = pend_de;
        pend_de  = d;
        pend_pix = d ? ref_pixel(hm, vm) : 0;
        if (d && hm == H - 1 && vm == V - 1) begin
            m_mode = m & 7;
            m_fc   = (m_fc + 1) & 'hFFFF;
`ifdef PATTERN_BOX_EN
            bounce(m_bx, m_xl, H);
            bounce(m_by, m_yu, V);
`endif
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic flush(input string tag, input int m);
        apply(tag, 1'b0, 0, 0, m);
        apply(tag, 1'b0, 0, 0, m);
    endtask

    initial begin
        rst_n = 1'b0; de = 1'b0; h_addr = '0; v_addr = '0; mode_i = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Colour bars across one full line
        for (int x = 0; x < H; x++) apply("bars", 1'b1, x, 0, 0);
        flush("bars", 0);

        // Mode request mid-frame only takes effect after eof
        for (int i = 0; i < 200; i++)
            apply("switch", 1'(i % 3 != 0), int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 2)), 2);
        apply("switch_eof", 1'b1, H - 1, V - 1, 2);
        apply("switch_new", 1'b1, 32, 0, 2);
        apply("switch_new", 1'b1, 0, 0, 2);
        for (int i = 0; i < 50; i++)
            apply("checker", 1'b1, int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)), 2);

        // Gray ramp then grid
        apply("ramp_eof", 1'b1, H - 1, V - 1, 1);
        for (int x = 0; x <= 300; x++) apply("ramp", 1'b1, x, 7, 1);
        apply("grid_eof", 1'b1, H - 1, V - 1, 3);
        apply("grid", 1'b1, 0, 17, 3);
        apply("grid", 1'b1, 32, 17, 3);
        apply("grid", 1'b1, 64, 17, 3);
        apply("grid", 1'b1, 1919, 17, 3);
        apply("grid", 1'b1, 33, 17, 3);
        for (int i = 0; i < 100; i++)
            apply("grid", 1'b1, int'($urandom_range(0, H - 1)), (i % 2) ? 0 : int'($urandom_range(0, V - 1)), 3);

        // Bouncing box over enough frames to hit both the right and bottom edges
        for (int f = 0; f < 480; f++) begin
            apply("box_eof", 1'b1, H - 1, V - 1, 4);
            apply("box", 1'b1, m_bx, m_by, 4);
            apply("box", 1'b1, m_bx + 63, m_by + 63, 4);
            apply("box", 1'b1, m_bx + 64, m_by, 4);
            apply("box", 1'b1, m_bx - 1, m_by, 4);
            apply("box", 1'b1, m_bx, m_by + 64, 4);
            apply("box", 1'($urandom_range(0, 1)), m_bx + int'($urandom_range(0, 70)) - 3,
                  m_by + int'($urandom_range(0, 70)) - 3, 4);
        end

        // Solid flood through frame-counter wrap
        apply("flood_eof", 1'b1, H - 1, V - 1, 5);
        while (m_fc != 'hFFFF) apply("flood", 1'b1, H - 1, V - 1, 5);
        apply("wrap_eof", 1'b1, H - 1, V - 1, 5);
        apply("wrap", 1'b1, 100, 100, 5);
        flush("wrap", 5);

        // Asynchronous reset in the middle of a frame
        apply("pre_rst", 1'b1, 900, 500, 5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outputs("in_rst");
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++)
            apply("post_rst", 1'b1, int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)), 4);
        apply("post_rst_eof", 1'b1, H - 1, V - 1, 4);
        apply("box_rst", 1'b1, 0, 0, 4);
        apply("box_rst", 1'b1, 63, 63, 4);
        apply("box_rst", 1'b1, 64, 0, 4);
        apply("box_rst", 1'b1, 10, 200, 4);

        // Random traffic including blanking, out-of-range addresses and eofs
        for (int i = 0; i < 2000; i++) begin
            int h, v;
            bit d;
            d = 1'($urandom_range(0, 3) != 0);
            h = int'($urandom_range(0, 4095));
            v = int'($urandom_range(0, 4095));
            if ($urandom_range(0, 49) == 0) begin
                d = 1'b1; h = H - 1; v = V - 1;
            end
            apply("random", d, h, v, int'($urandom_range(0, 7)));
        end
        flush("random", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Parametrised multi-mode video test-pattern generator. Sits between the display timing generator and the video output/encoder stage. Produces one RGB pixel per clock for the current active-area address. Mode is selectable at runtime and switches only on frame boundaries; a bouncing-box pattern animates once per frame.

## Interface
Parameters:
- H_ACTIVE, 1920, active pixels per line
- V_ACTIVE, 1080, active lines per frame
- ADDR_W, 12, width of h_addr/v_addr
- COLOR_W, 8, bits per colour channel; pixel width = 3*COLOR_W (R high, B low)
- BAR_SHIFT, 8, colour-bar width = 2^BAR_SHIFT pixels
- CHK_SHIFT, 5, checker/grid cell size = 2^CHK_SHIFT pixels
- BOX_SIZE, 64, box edge in pixels (< H_ACTIVE, < V_ACTIVE)
- BOX_STEP, 4, box displacement per frame on each axis

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- de  in  1  active-area data enable
- h_addr  in  ADDR_W  active pixel column, valid when de=1
- v_addr  in  ADDR_W  active line, valid when de=1
- mode_i  in  3  requested pattern mode, sampled at end of frame
- data_disp  out  3*COLOR_W  pixel colour
- de_o  out  1  de delayed to align with data_disp
- mode_o  out  3  mode currently in effect
- frame_cnt  out  16  completed-frame counter

## Operation
- eof = de && h_addr==H_ACTIVE-1 && v_addr==V_ACTIVE-1 (last active pixel).
- On eof, all of the following happen:
  - mode_o <= mode_i.
  - frame_cnt <= frame_cnt+1. It wraps 0xFFFF->0.
  - The box position updates.
- The eof pixel itself is still rendered with the old mode and the old box.
- Modes; channel full-scale F = all ones:
  - 0 colour bars. idx = (h_addr>>BAR_SHIFT) mod 8. Colours in order: red, green, blue, yellow, cyan, magenta, grey (0xC0 scaled to COLOR_W MSBs), white.
  - 1 gray ramp. R=G=B=h_addr[COLOR_W-1:0]. Wraps every 2^COLOR_W pixels.
  - 2 checkerboard. White if h_addr[CHK_SHIFT]^v_addr[CHK_SHIFT], else black.
  - 3 grid. White if h_addr[CHK_SHIFT-1:0]==0, v_addr[CHK_SHIFT-1:0]==0, h_addr==H_ACTIVE-1 or v_addr==V_ACTIVE-1. Else black.
  - 4 moving box. Red inside box_x<=h_addr<box_x+BOX_SIZE and box_y<=v_addr<box_y+BOX_SIZE. Else blue.
  - 5 solid flood. Bar colour idx = frame_cnt[8:6], so the colour changes every 64 frames.
  - 6, 7 black.
- Box update on eof, x axis (y identical with V_ACTIVE, dir_y):
  - Moving right: if box_x+BOX_SIZE+BOX_STEP > H_ACTIVE, then box_x <= H_ACTIVE-BOX_SIZE and dir_x <= left. Else box_x <= box_x+BOX_STEP.
  - Moving left: if box_x < BOX_STEP, then box_x <= 0 and dir_x <= right. Else box_x <= box_x-BOX_STEP.
  - Compare in ADDR_W+1 bits; no overflow.
- The box updates on every eof regardless of mode.
- When de=0 at the input, data_disp is black on the corresponding output cycle.

## Timing
- Latency: 2 clocks, input to data_disp/de_o.
  - Stage 1 registers de, addresses, mode select and region/bar decisions.
  - Stage 2 registers the colour.
- de_o = de delayed 2 clocks. No pixels are dropped or duplicated.
- mode_o, frame_cnt and box state update at the clock edge after eof.
- A mode_i change mid-frame has no effect until the next eof.
- Reset, asynchronous, values:
  - data_disp=0, de_o=0, mode_o=0, frame_cnt=0.
  - box_x=0, box_y=0, dir right/down.
  - Pipeline registers cleared.
- Reset mid-frame: outputs go black immediately. After release, rendering restarts in mode 0 with the next valid de.
- An out-of-range address with de=1 (h_addr>=H_ACTIVE) renders per mode formula, with no special handling.

## Configuration
- PATTERN_BOX_EN defined:
  - Box registers and mode 4 are compiled in.
- PATTERN_BOX_EN undefined:
  - No box registers are generated.
  - Mode 4 renders black.
  - All other modes are unchanged.

## Test plan
- Colour bars: H_ACTIVE=1920, mode 0, one line. Required response:
  - data_disp 0xFF0000 for x=0..255.
  - data_disp 0x00FF00 for x=256..511.
  - Continues through the bar order to 0xFFFFFF for x=1792..1919.
  - de_o rises exactly 2 clocks after de.
- Mode switch: mode_i 0->2 asserted mid-frame. Required response:
  - Remainder of the frame stays bars.
  - mode_o=2 from the clock edge after eof.
  - Next frame pixel (32,0) is white; pixel (0,0) is black.
- Box bounce: PATTERN_BOX_EN, BOX_STEP=4, BOX_SIZE=64. Run 470 frames. Required response:
  - box_x reaches 1856 = H_ACTIVE-64 and dir flips.
  - Next frame box_x=1852.
  - Pixel (box_x,box_y)=0xFF0000 and (box_x+64,box_y)=0x0000FF.
- Ramp/grid: mode 1, x=0..300. Required response:
  - gray 0x00..0xFF, then 0x00 at x=256.
  - Mode 3: x=0,32,64 and y=0 lines white; x=1919 white.
- Counter wrap: force frame_cnt=0xFFFF, one eof. Required response:
  - frame_cnt=0.
  - Mode 5 colour returns to red.
- Reset mid-frame: pull rst_n low at pixel (900,500). Required response:
  - data_disp=0, de_o=0 and mode_o=0 asynchronously.
  - After release, the first valid pixel appears 2 clocks later in mode 0.
  - With PATTERN_BOX_EN undefined, mode 4 gives all black.
